// File: rtl/apb4_archinfo_ext.sv
`default_nettype none
// ============================================================================
// Module   : apb4_archinfo_ext
// Brief    : APB4 completer exposing read-only info words, scratch registers
//            and a 64-bit free-running cycle counter with a coherent high snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_archinfo_ext #(
    parameter int                     NUM_INFO    = 3,
    parameter logic [NUM_INFO*32-1:0] INFO_VAL    = {32'hFFFF_FFFF, 32'hFFFF_2022, 32'h101F_1010},
    parameter int                     NUM_SCRATCH = 2,
    parameter int                     WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] paddr,
    input  logic [2:0]  pprot,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);

    localparam logic [5:0] c_SCR_BASE = 6'd16;
    localparam logic [5:0] c_CNT_LO   = 6'd24;
    localparam logic [5:0] c_CNT_HI   = 6'd25;
    localparam logic [5:0] c_CTRL     = 6'd26;
    localparam logic [3:0] c_WAIT     = 4'(WAIT_CYCLES);

    logic [3:0]  r_wait_cnt;
    logic [31:0] r_scratch [NUM_SCRATCH];
    logic [63:0] r_counter;
    logic [31:0] r_snap_hi;
    logic        r_cnt_en;

    logic [5:0]  w_word;
    logic        w_is_info, w_is_scr, w_is_lo, w_is_hi, w_is_ctrl;
    logic        w_done, w_wr_done, w_rd_done, w_err;
    logic        w_ctrl_wr;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_unused_bits = ^{pprot, paddr[31:8], paddr[1:0]};

    assign w_word    = paddr[7:2];
    assign w_is_info = (w_word < 6'(NUM_INFO));
    assign w_is_scr  = (w_word >= c_SCR_BASE) && (w_word < 6'(16 + NUM_SCRATCH));
    assign w_is_lo   = (w_word == c_CNT_LO);
    assign w_is_hi   = (w_word == c_CNT_HI);
    assign w_is_ctrl = (w_word == c_CTRL);

    // Wait counter is reloaded whenever no access phase is in progress, which
    // also covers abandoned transfers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (!psel || !penable) begin
            r_wait_cnt <= c_WAIT;
        end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    assign pready    = ~(psel & penable & (r_wait_cnt != 4'd0));
    assign w_done    = psel & penable & pready & ~rst_i;
    assign w_wr_done = w_done & pwrite;
    assign w_rd_done = w_done & ~pwrite;
    assign w_ctrl_wr = w_wr_done & w_is_ctrl & pstrb[0];

    assign w_err = pwrite ? ~(w_is_scr | w_is_ctrl)
                          : ~(w_is_info | w_is_scr | w_is_lo | w_is_hi | w_is_ctrl);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < NUM_SCRATCH; j++) begin
                r_scratch[j] <= '0;
            end
        end else if (w_wr_done) begin
            for (int j = 0; j < NUM_SCRATCH; j++) begin
                if (w_word == 6'(16 + j)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (pstrb[k]) begin
                            r_scratch[j][k*8 +: 8] <= pwdata[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Clear wins over increment; CNT_CLR itself is never stored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_counter <= '0;
            r_snap_hi <= '0;
            r_cnt_en  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_cnt_en <= pwdata[0];
            end
            if (w_ctrl_wr && pwdata[1]) begin
                r_counter <= '0;
            end else if (r_cnt_en) begin
                r_counter <= r_counter + 64'd1;
            end
            if (w_rd_done && w_is_lo) begin
                r_snap_hi <= r_counter[63:32];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_INFO; i++) begin
            if (w_word == 6'(i)) begin
                w_rdata = INFO_VAL[i*32 +: 32];
            end
        end
        for (int j = 0; j < NUM_SCRATCH; j++) begin
            if (w_word == 6'(16 + j)) begin
                w_rdata = r_scratch[j];
            end
        end
        if (w_is_lo) begin
            w_rdata = r_counter[31:0];
        end
        if (w_is_hi) begin
            w_rdata = r_snap_hi;
        end
        if (w_is_ctrl) begin
            w_rdata = {31'd0, r_cnt_en};
        end
    end

    assign prdata  = w_rd_done ? w_rdata : 32'd0;
    assign pslverr = w_done & w_err;

endmodule
`default_nettype wire

// File: tb/tb_apb4_archinfo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_archinfo_ext
// Brief    : Scoreboard bench for apb4_archinfo_ext (zero-wait and 3-wait copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_archinfo_ext;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] paddr, pwdata;
    logic [2:0]  pprot;
    logic        penable, pwrite;
    logic [3:0]  pstrb;
    logic        psel0, psel3;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3;

    always #5 clk = ~clk;

    apb4_archinfo_ext #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .paddr(paddr), .pprot(pprot), .psel(psel0),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
    );

    apb4_archinfo_ext #(.WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .paddr(paddr), .pprot(pprot), .psel(psel3),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        logic        chk;
        logic [95:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: pops one expectation per completed transfer on either copy.
    always @(negedge clk) begin
        logic [31:0] d;
        logic        e;
        exp_t        x;
        if (!rst_i && penable && ((psel0 && pready0) || (psel3 && pready3))) begin
            d = psel0 ? prdata0 : prdata3;
            e = psel0 ? pslverr0 : pslverr3;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_completion: got data=%h err=%b, required none", d, e);
            end else begin
                x = sb.pop_front();
                if (e !== x.err || (x.chk && ($isunknown(d) || d < x.lo || d > x.hi))) begin
                    n_bad++;
                    $display("FAIL %s: got data=%h err=%b, required data in [%h,%h] err=%b",
                             x.tag, d, e, x.lo, x.hi, x.err);
                end
            end
        end
    end

    task automatic chk(input logic [95:0] tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", tag, act, exp);
        end
    endtask

    task automatic xfer(input bit u3, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] lo, input logic [31:0] hi,
                        input bit err, input int expw, input logic [95:0] tag);
        exp_t x;
        int   waits;
        @(posedge clk); #1;
        paddr = a; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
        if (u3) psel3 = 1'b1; else psel0 = 1'b1;
        x.lo = lo; x.hi = hi; x.err = err; x.chk = !wr; x.tag = tag;
        sb.push_back(x);
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (u3 ? pready3 : pready0) break;
            waits++;
            if (waits > 40) begin
                n_vec++; n_bad++;
                $display("FAIL %s: pready timeout after %0d cycles, required completion", tag, waits);
                void'(sb.pop_back());
                break;
            end
        end
        if (expw >= 0) chk("wait_states", 32'(waits), 32'(expw));
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic rd(input bit u3, input logic [31:0] a, input logic [31:0] exp, input bit err,
                      input logic [95:0] tag);
        xfer(u3, 1'b0, a, 32'd0, 4'h0, exp, exp, err, u3 ? 3 : 0, tag);
    endtask

    task automatic wr(input bit u3, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      input bit err, input logic [95:0] tag);
        xfer(u3, 1'b1, a, d, st, 32'd0, 32'd0, err, u3 ? 3 : 0, tag);
    endtask

    initial begin
        rst_i = 1'b1; paddr = '0; pwdata = '0; pprot = 3'b000; penable = 1'b0;
        pwrite = 1'b0; pstrb = '0; psel0 = 1'b0; psel3 = 1'b0;
        #2;
        chk("rst_pready0", {31'd0, pready0}, 32'd1);
        chk("rst_prdata0", prdata0, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        chk("rst_pready3", {31'd0, pready3}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        // Info words, scratch lanes, error responses
        rd(0, 32'h00, 32'h101F_1010, 0, "info0");
        rd(0, 32'h04, 32'hFFFF_2022, 0, "info1");
        rd(0, 32'hFFFF_FF08, 32'hFFFF_FFFF, 0, "info2_hiaddr");
        wr(0, 32'h40, 32'hA5A5_A5A5, 4'b0101, 0, "scr0_wr");
        rd(0, 32'h43, 32'h00A5_00A5, 0, "scr0_rd");
        wr(0, 32'h0C, 32'h1234_5678, 4'hF, 1, "wr_unmap0C");
        wr(0, 32'h00, 32'h1234_5678, 4'hF, 1, "wr_info0");
        rd(0, 32'h00, 32'h101F_1010, 0, "info0_again");
        rd(0, 32'h0C, 32'h0, 1, "rd_unmap0C");
        rd(0, 32'h7C, 32'h0, 1, "rd_unmap7C");
        rd(0, 32'h48, 32'h0, 1, "rd_scr_oob");
        wr(0, 32'h44, 32'hFFFF_FFFF, 4'h0, 0, "scr1_nostrb");
        rd(0, 32'h44, 32'h0, 0, "scr1_rd");

        // Cycle counter, clear, snapshot
        wr(0, 32'h68, 32'h1, 4'h1, 0, "ctrl_en");
        repeat (100) @(posedge clk);
        xfer(0, 1'b0, 32'h60, 0, 0, 32'd100, 32'd110, 0, 0, "cnt_lo_100");
        rd(0, 32'h64, 32'h0, 0, "cnt_hi_0");
        wr(0, 32'h68, 32'h3, 4'h1, 0, "ctrl_clr");
        xfer(0, 1'b0, 32'h60, 0, 0, 32'd0, 32'd9, 0, 0, "cnt_lo_clr");
        rd(0, 32'h68, 32'h1, 0, "ctrl_rd");
        wr(0, 32'h60, 32'h0, 4'hF, 1, "wr_cnt_lo");
        wr(0, 32'h64, 32'h0, 4'hF, 1, "wr_cnt_hi");

        // Wrap crossing of the low half
        @(negedge clk);
        force dut0.r_counter = 64'h0000_0000_FFFF_FFFE;
        @(posedge clk); #1;
        release dut0.r_counter;
        repeat (5) @(posedge clk);
        xfer(0, 1'b0, 32'h60, 0, 0, 32'd0, 32'd20, 0, 0, "cnt_lo_wrap");
        rd(0, 32'h64, 32'h1, 0, "cnt_hi_snap");
        rd(0, 32'h64, 32'h1, 0, "cnt_hi_again");

        // Three wait states
        wr(1, 32'h40, 32'h1234_5678, 4'hF, 0, "w3_scr0_wr");
        rd(1, 32'h40, 32'h1234_5678, 0, "w3_scr0_rd");
        @(posedge clk); #1;
        paddr = 32'h44; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; psel3 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abandon_pready", {31'd0, pready3}, 32'd0);
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0;
        rd(1, 32'h44, 32'h0, 0, "w3_abandon");

        // Reset in the middle of a waited write
        wr(1, 32'h68, 32'h1, 4'h1, 0, "w3_ctrl_en");
        @(posedge clk); #1;
        paddr = 32'h48 - 32'h4; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; psel3 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_pready", {31'd0, pready3}, 32'd1);
        chk("midrst_prdata", prdata3, 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        rd(1, 32'h44, 32'h0, 0, "w3_rst_scr1");
        rd(1, 32'h40, 32'h0, 0, "w3_rst_scr0");
        rd(1, 32'h68, 32'h0, 0, "w3_rst_ctrl");

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
